// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 load/store path: opcodes, FSM states,
// access sizes and an opcode decoder.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWT,
        WR,
        DONE
    } ls_state_t;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } ls_size_t;

    typedef struct packed {
        logic     valid;
        logic     is_load;
        ls_size_t size;
        logic     sign_ext;
    } op_info_t;

    // Decode an opcode into access class; unknown opcodes come back with valid=0.
    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{valid: 1'b1, is_load: 1'b1, size: WORD, sign_ext: 1'b0};
        case (op)
            OP_LB:  begin info.size = BYTE; info.sign_ext = 1'b1; end
            OP_LH:  begin info.size = HALF; info.sign_ext = 1'b1; end
            OP_LW:  info.size = WORD;
            OP_LBU: info.size = BYTE;
            OP_LHU: info.size = HALF;
            OP_SB:  begin info.size = BYTE; info.is_load = 1'b0; end
            OP_SH:  begin info.size = HALF; info.is_load = 1'b0; end
            OP_SW:  begin info.size = WORD; info.is_load = 1'b0; end
            default: info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/load_store_controller_if.sv
// Pipeline-side request/response and data-memory signals of the load/store
// controller. The controller uses the slave view; the pipeline/memory side
// uses the master view.
interface load_store_controller_if #(
    parameter int unsigned MEM_AW = 11
);
    logic              req;
    logic [5:0]        opcode;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req, opcode, addr, wdata, mem_rdata,
        input  ready, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req, opcode, addr, wdata, mem_rdata,
        output ready, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lane_unit.sv
// Combinational byte-lane steering: extracts and extends a load value from a
// memory word, and merges store data into a word for read-modify-write.
module lane_unit
    import mips_mem_pkg::*;
#(
    parameter bit BIG_END = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  ls_size_t    size,
    input  logic        sign_ext,
    input  logic [31:0] sdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [15:0] lane;

    // Lane position, extraction/extension and store merge.
    always_comb begin
        shamt = '0;
        mask  = '1;
        case (size)
            BYTE: begin
                shamt = BIG_END ? {~offset, 3'b000} : {offset, 3'b000};
                mask  = 32'h0000_00FF;
            end
            HALF: begin
                shamt = BIG_END ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
                mask  = 32'h0000_FFFF;
            end
            default: ;
        endcase

        lane = 16'(word >> shamt);
        case (size)
            BYTE:    load_val = {{24{sign_ext & lane[7]}}, lane[7:0]};
            HALF:    load_val = {{16{sign_ext & lane[15]}}, lane[15:0]};
            default: load_val = word;
        endcase

        merged = (word & ~(mask << shamt)) | ((sdata & mask) << shamt);
    end
endmodule

// File: rtl/load_store_controller.sv
// Sequences MIPS32 loads/stores onto a single-port word memory; sub-word
// stores are done as read-modify-write so memory sees only full words.
module load_store_controller
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_AW  = 11,
    parameter bit          BIG_END = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    load_store_controller_if.slave bus
);
    ls_state_t         state_q, state_d;
    op_info_t          info_q, info_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [31:0]       store_q, store_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    op_info_t          dec;
    logic              misaligned;
    logic              out_of_range;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    lane_unit #(.BIG_END(BIG_END)) u_lane (
        .word     (bus.mem_rdata),
        .offset   (addr_q[1:0]),
        .size     (info_q.size),
        .sign_ext (info_q.sign_ext),
        .sdata    (store_q),
        .load_val (load_val),
        .merged   (merged)
    );

    // Classify the incoming request.
    always_comb begin
        dec          = decode_op(bus.opcode);
        misaligned   = ((dec.size == HALF) && bus.addr[0]) ||
                       ((dec.size == WORD) && (bus.addr[1:0] != 2'b00));
        out_of_range = (bus.addr >> (MEM_AW + 2)) != '0;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        info_d  = info_q;
        addr_d  = addr_q;
        store_d = store_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    info_d  = dec;
                    addr_d  = bus.addr[MEM_AW+1:0];
                    store_d = bus.wdata;
                    err_d   = !dec.valid || misaligned || out_of_range;
                    if (!dec.valid || misaligned || out_of_range) begin
                        state_d = DONE;
                    end else if (dec.is_load || (dec.size != WORD)) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD:  state_d = RWT;
            RWT: begin
                if (info_q.is_load) begin
                    rdata_d = load_val;
                    state_d = DONE;
                end else begin
                    store_d = merged;
                    state_d = WR;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            info_q  <= '0;
            addr_q  <= '0;
            store_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            info_q  <= info_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.ready     = (state_q == IDLE);
        bus.done      = (state_q == DONE);
        bus.err       = (state_q == DONE) && err_q;
        bus.rdata     = rdata_q;
        bus.mem_addr  = addr_q[MEM_AW+1:2];
        bus.mem_re    = (state_q == RD);
        bus.mem_we    = (state_q == WR);
        bus.mem_wdata = store_q;
    end
endmodule

// File: tb/tb_load_store_controller.sv
// Self-checking bench for load_store_controller: directed vector table,
// reset-abort and handshake sequences, then randomized accesses checked
// against a byte-addressed reference memory model.
module tb_load_store_controller;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    load_store_controller_if #(.MEM_AW(11)) bus();

    load_store_controller #(.MEM_AW(11), .BIG_END(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Word memory attached to the DUT
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Reference model: little-endian byte memory
    logic [7:0]  ref_mem [0:8191];
    logic [31:0] last_rdata;

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
    endtask

    task automatic model_access(input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] wd, output bit e,
                                output bit ld, output int n, output logic [31:0] val);
        bit sgn;
        e = 0; ld = 1; sgn = 0; n = 4; val = '0;
        case (op)
            6'h20: begin n = 1; sgn = 1; end
            6'h21: begin n = 2; sgn = 1; end
            6'h23: n = 4;
            6'h24: n = 1;
            6'h25: n = 2;
            6'h28: begin n = 1; ld = 0; end
            6'h29: begin n = 2; ld = 0; end
            6'h2B: begin n = 4; ld = 0; end
            default: e = 1;
        endcase
        if (a % n != 0) e = 1;
        if (a >= 32'd8192) e = 1;
        if (e) return;
        if (ld) begin
            for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[a+i];
            if (sgn && val[8*n-1])
                for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Issue one access and observe it until done (bounded).
    task automatic do_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                             output bit g_err, output int lat, output int re_n, output int we_n,
                             output int re_cyc, output int we_cyc, output logic [31:0] we_data,
                             output logic [31:0] g_rdata, output bit overlap, output bit addr_bad);
        int guard;
        int cyc;
        g_err = 0; lat = 0; re_n = 0; we_n = 0; re_cyc = 0; we_cyc = 0;
        we_data = '0; g_rdata = '0; overlap = 0; addr_bad = 0; guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req = 1'b1; bus.opcode = op; bus.addr = a; bus.wdata = wd;
        @(negedge clk);
        bus.req = 1'b0;
        for (cyc = 1; cyc <= 10; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (bus.mem_re) begin re_n++; if (re_cyc == 0) re_cyc = cyc; end
            if (bus.mem_we) begin we_n++; if (we_cyc == 0) we_cyc = cyc; we_data = bus.mem_wdata; end
            if (bus.mem_re && bus.mem_we) overlap = 1;
            if ((bus.mem_re || bus.mem_we) && (bus.mem_addr != a[12:2])) addr_bad = 1;
            if (bus.done) begin
                lat = cyc; g_err = bus.err; g_rdata = bus.rdata;
                break;
            end
        end
    endtask

    // Run one access, compare against the reference model; results returned for extra checks.
    task automatic run_check(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] wd, output bit g_err, output int lat,
                             output int re_cyc, output int we_cyc, output logic [31:0] we_data,
                             output logic [31:0] g_rdata);
        bit e, ld, ov, ab;
        int n, re_n, we_n, elat;
        logic [31:0] val;
        model_access(op, a, wd, e, ld, n, val);
        if (!e && ld) last_rdata = val;
        elat = e ? 1 : (ld ? 3 : (n == 4 ? 2 : 4));
        do_access(op, a, wd, g_err, lat, re_n, we_n, re_cyc, we_cyc, we_data, g_rdata, ov, ab);
        chk({tag, ".err"}, 32'(g_err), 32'(e));
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".rdata"}, g_rdata, last_rdata);
        chk({tag, ".re_n"}, re_n, (!e && (ld || n != 4)) ? 1 : 0);
        chk({tag, ".we_n"}, we_n, (!e && !ld) ? 1 : 0);
        if (!e && !ld) chk({tag, ".wdata"}, we_data, ref_word(int'(a >> 2)));
        if (ov || ab) chk({tag, ".bus_rules"}, {30'd0, ov, ab}, 32'd0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        bit          e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_re_cyc;
        int          e_we_cyc;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [12];
    logic [5:0] ops [8];

    initial begin
        bit g_err;
        int lat, re_cyc, we_cyc;
        logic [31:0] we_data, g_rdata, saved;

        vecs[0]  = '{OP_LW,  32'h10,   32'h0,        0, 32'h8899AABB, 3, 1, 0, 32'h0};
        vecs[1]  = '{OP_LB,  32'h11,   32'h0,        0, 32'hFFFFFFAA, 3, 1, 0, 32'h0};
        vecs[2]  = '{OP_LBU, 32'h11,   32'h0,        0, 32'h000000AA, 3, 1, 0, 32'h0};
        vecs[3]  = '{OP_LH,  32'h12,   32'h0,        0, 32'hFFFF8899, 3, 1, 0, 32'h0};
        vecs[4]  = '{OP_SB,  32'h13,   32'h12345677, 0, 32'hFFFF8899, 4, 1, 3, 32'h7799AABB};
        vecs[5]  = '{OP_LW,  32'h10,   32'h0,        0, 32'h7799AABB, 3, 1, 0, 32'h0};
        vecs[6]  = '{OP_SW,  32'h10,   32'hDEADBEEF, 0, 32'h7799AABB, 2, 0, 1, 32'hDEADBEEF};
        vecs[7]  = '{OP_SH,  32'h11,   32'h0,        1, 32'h7799AABB, 1, 0, 0, 32'h0};
        vecs[8]  = '{OP_LW,  32'h4000, 32'h0,        1, 32'h7799AABB, 1, 0, 0, 32'h0};
        vecs[9]  = '{6'h3F,  32'h10,   32'h0,        1, 32'h7799AABB, 1, 0, 0, 32'h0};
        vecs[10] = '{OP_LHU, 32'h10,   32'h0,        0, 32'h0000BEEF, 3, 1, 0, 32'h0};
        vecs[11] = '{OP_LH,  32'h10,   32'h0,        0, 32'hFFFFBEEF, 3, 1, 0, 32'h0};
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
        for (int w = 0; w < 2048; w++) mem[w] = '0;
        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        set_word(4, 32'h8899AABB);
        last_rdata = '0;

        bus.req = 1'b0; bus.opcode = '0; bus.addr = '0; bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready",     32'(bus.ready),  32'd1);
        chk("rst.done",      32'(bus.done),   32'd0);
        chk("rst.err",       32'(bus.err),    32'd0);
        chk("rst.mem_re",    32'(bus.mem_re), 32'd0);
        chk("rst.mem_we",    32'(bus.mem_we), 32'd0);
        chk("rst.rdata",     bus.rdata,       32'd0);
        chk("rst.mem_addr",  32'(bus.mem_addr), 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata,   32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_check(t, vecs[i].op, vecs[i].a, vecs[i].wd, g_err, lat, re_cyc, we_cyc, we_data, g_rdata);
            chk({t, ".tbl_err"},   32'(g_err), 32'(vecs[i].e_err));
            chk({t, ".tbl_rdata"}, g_rdata,    vecs[i].e_rdata);
            chk({t, ".tbl_lat"},   lat,        vecs[i].e_lat);
            chk({t, ".tbl_re_cyc"}, re_cyc,    vecs[i].e_re_cyc);
            chk({t, ".tbl_we_cyc"}, we_cyc,    vecs[i].e_we_cyc);
            if (vecs[i].e_we_cyc != 0) chk({t, ".tbl_wdata"}, we_data, vecs[i].e_wdata);
        end

        // Reset during RWT of a byte store aborts it with no write
        begin
            int we_seen;
            int guard;
            we_seen = 0; guard = 0;
            saved = mem[5];
            @(negedge clk);
            while (!bus.ready && guard < 20) begin @(negedge clk); guard++; end
            bus.req = 1'b1; bus.opcode = OP_SB; bus.addr = 32'h14; bus.wdata = 32'hA5;
            @(negedge clk);
            bus.req = 1'b0;
            if (bus.mem_we) we_seen++;
            @(negedge clk);
            if (bus.mem_we) we_seen++;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort.ready", 32'(bus.ready), 32'd1);
            chk("abort.done",  32'(bus.done),  32'd0);
            chk("abort.rdata", bus.rdata,      32'd0);
            last_rdata = '0;
            for (int c = 0; c < 5; c++) begin
                if (bus.mem_we || bus.done) we_seen++;
                @(negedge clk);
            end
            chk("abort.no_write", we_seen, 0);
            chk("abort.mem",      mem[5],  saved);
        end

        // req held high: two back-to-back lw accesses
        begin
            int acc [2];
            int dn [2];
            int na, nd, both;
            logic [31:0] v;
            bit e, ld;
            int n;
            na = 0; nd = 0; both = 0;
            acc = '{-1, -1}; dn = '{-1, -1};
            model_access(OP_LW, 32'h10, 32'h0, e, ld, n, v);
            @(negedge clk);
            bus.req = 1'b1; bus.opcode = OP_LW; bus.addr = 32'h10; bus.wdata = '0;
            for (int c = 0; c < 16 && nd < 2; c++) begin
                if (c > 0) @(negedge clk);
                if (bus.ready && bus.req) begin
                    if (na < 2) acc[na] = c;
                    na++;
                end
                if (bus.ready && bus.done) both++;
                if (bus.done) begin
                    if (nd < 2) dn[nd] = c;
                    nd++;
                    if (nd == 2) begin
                        bus.req = 1'b0;
                        chk("hs.rdata", bus.rdata, v);
                    end
                end
            end
            bus.req = 1'b0;
            last_rdata = v;
            chk("hs.accepts", na, 2);
            chk("hs.acc0",    acc[0], 0);
            chk("hs.done0",   dn[0],  3);
            chk("hs.acc1",    acc[1], 4);
            chk("hs.done1",   dn[1],  7);
            chk("hs.overlap", both,   0);
        end

        // Randomized accesses against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  op;
            logic [31:0] a, wd;
            int r, off;
            r  = int'($urandom_range(0, 15));
            op = ops[$urandom_range(0, 7)];
            if (r == 0) op = 6'($urandom_range(0, 63));
            off = int'($urandom_range(0, 3));
            if (r >= 3 && (op == OP_LH || op == OP_LHU || op == OP_SH)) off = off & 2;
            if (r >= 3 && (op == OP_LW || op == OP_SW)) off = 0;
            a  = 32'($urandom_range(0, 63)) * 4 + 32'(off);
            if (r == 1) a = a | (32'd1 << $urandom_range(13, 31));
            wd = $urandom;
            run_check($sformatf("rnd%0d", i), op, a, wd, g_err, lat, re_cyc, we_cyc, we_data, g_rdata);
        end

        for (int w = 0; w < 64; w++)
            chk($sformatf("final.mem%0d", w), mem[w], ref_word(w));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
